// File: rtl/simul_axi_master_wdata_gen_pkg.sv
// Shared definitions for the AXI write-data master model: output state
// encoding and the packed payload width helper.
package simul_axi_master_wdata_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    GAP   = 2'd2
  } wstate_e;

  // Packed payload is {id, data, strb, last}.
  function automatic int payload_width(input int id_w, input int data_w, input int strb_w);
    return id_w + data_w + strb_w + 1;
  endfunction

endpackage

// File: rtl/simul_fifo_sync.sv
// Synchronous FIFO with occupancy count. Pop on empty is ignored; push on
// full is ignored unless a pop frees a slot in the same cycle.
module simul_fifo_sync #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage; contents need no reset since count gates their use.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/simul_axi_master_wdata_gen.sv
// AXI W-channel master model: commands pass a LATENCY-deep delay pipe into
// a FIFO and are issued with a programmable idle gap after every beat.
// Optional macro SIMUL_AXI_WDATA_CHECK_EN adds a per-burst wid consistency
// check driving id_err; without it id_err is tied low.
module simul_axi_master_wdata_gen
  import simul_axi_master_wdata_gen_pkg::*;
#(
  parameter  int ID_WIDTH   = 12,
  parameter  int DATA_WIDTH = 32,
  parameter  int WSTB_WIDTH = DATA_WIDTH / 8,
  parameter  int LATENCY    = 0,
  parameter  int DEPTH      = 8,
  localparam int LW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ID_WIDTH-1:0]   wid_in,
  input  logic [DATA_WIDTH-1:0] wdata_in,
  input  logic [WSTB_WIDTH-1:0] wstrb_in,
  input  logic                  wlast_in,
  input  logic                  set_cmd,
  output logic                  ready,
  input  logic [3:0]            gap,
  output logic [ID_WIDTH-1:0]   wid,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [WSTB_WIDTH-1:0] wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [LW-1:0]         level,
  output logic [15:0]           bursts,
  output logic                  overflow,
  output logic                  id_err
);

  localparam int PW = payload_width(ID_WIDTH, DATA_WIDTH, WSTB_WIDTH);

  wstate_e       state_q, state_d;
  logic [3:0]    gcnt_q, gcnt_d;
  logic [LW-1:0] level_q, fifo_cnt;
  logic          accept, pop, fifo_push;
  logic [PW-1:0] cmd_in, fifo_din, fifo_dout, out_pl;
  logic [15:0]   bursts_q;
  logic          overflow_q;

  assign cmd_in = {wid_in, wdata_in, wstrb_in, wlast_in};
  // level covers pipe + FIFO, so the FIFO itself can never overfill.
  assign ready  = level_q < LW'(DEPTH);
  assign accept = set_cmd && ready;

  generate
    if (LATENCY == 0) begin : g_direct
      assign fifo_push = accept;
      assign fifo_din  = cmd_in;
    end else begin : g_delay
      for (genvar g = 0; g < LATENCY; g++) begin : g_stage
        logic          v, v_prev;
        logic [PW-1:0] d, d_prev;
        if (g == 0) begin : g_src
          assign v_prev = accept;
          assign d_prev = cmd_in;
        end else begin : g_chain
          assign v_prev = g_stage[g-1].v;
          assign d_prev = g_stage[g-1].d;
        end
        // One delay stage; valid flag travels alongside the payload.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            v <= 1'b0;
            d <= '0;
          end else begin
            v <= v_prev;
            d <= d_prev;
          end
        end
      end
      assign fifo_push = g_stage[LATENCY-1].v;
      assign fifo_din  = g_stage[LATENCY-1].d;
    end
  endgenerate

  simul_fifo_sync #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (fifo_din),
    .pop     (pop),
    .dout    (fifo_dout),
    .count   (fifo_cnt)
  );

  // Output sequencer: issue head, then optionally idle for gap cycles.
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_cnt != '0) state_d = VALID;
      end
      VALID: begin
        if (wready) begin
          pop = 1'b1;
          if (gap == 4'd0) begin
            state_d = (fifo_cnt > LW'(1)) ? VALID : IDLE;
          end else begin
            state_d = GAP;
            gcnt_d  = gap;
          end
        end
      end
      GAP: begin
        gcnt_d = gcnt_q - 4'd1;
        if (gcnt_q <= 4'd1) state_d = (fifo_cnt != '0) ? VALID : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and gap counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // Pipe + FIFO occupancy, burst counter and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q    <= '0;
      bursts_q   <= 16'd0;
      overflow_q <= 1'b0;
    end else begin
      if (accept && !pop)      level_q <= level_q + LW'(1);
      else if (!accept && pop) level_q <= level_q - LW'(1);
      if (pop && wlast)        bursts_q <= bursts_q + 16'd1;
      if (set_cmd && !ready)   overflow_q <= 1'b1;
    end
  end

  assign wvalid   = (state_q == VALID);
  assign out_pl   = wvalid ? fifo_dout : '0;
  assign {wid, wdata, wstrb, wlast} = out_pl;
  assign level    = level_q;
  assign bursts   = bursts_q;
  assign overflow = overflow_q;

`ifdef SIMUL_AXI_WDATA_CHECK_EN
  logic                first_q;
  logic [ID_WIDTH-1:0] burst_id_q;
  logic                id_err_q;

  // Latch the first beat's wid of each burst and flag later mismatches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first_q    <= 1'b1;
      burst_id_q <= '0;
      id_err_q   <= 1'b0;
    end else if (pop) begin
      if (first_q) begin
        burst_id_q <= wid;
      end else if (wid != burst_id_q) begin
        id_err_q <= 1'b1;
        $display("simul_axi_master_wdata_gen: wid %h differs from burst wid %h", wid, burst_id_q);
      end
      first_q <= wlast;
    end
  end

  assign id_err = id_err_q;
`else
  assign id_err = 1'b0;
`endif

endmodule

// File: doc/simul_axi_master_wdata_gen.md
# simul_axi_master_wdata_gen

Parametrised AXI write-data channel master model for the SATA top-level testbench. It generalises the fixed 32-bit write-data driver to any data width and queue depth. It adds a programmable inter-beat gap, a burst counter, fill-level reporting and overflow detection. It sits between the task layer (`set_cmd`/`ready`) and the `MAXIGP0W*` port of the device under test.

## Interface
- `ID_WIDTH`, 12, width of `wid`
- `DATA_WIDTH`, 32, write data width; must be a multiple of 8
- `WSTB_WIDTH`, `DATA_WIDTH/8`, strobe width
- `LATENCY`, 0, extra cycles between command capture and earliest `wvalid` (0 means the next cycle)
- `DEPTH`, 8, total commands held (delay pipe + FIFO); power of 2, at least 2
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `wid_in`  in  `ID_WIDTH`  command ID
- `wdata_in`  in  `DATA_WIDTH`  command data
- `wstrb_in`  in  `WSTB_WIDTH`  command strobes
- `wlast_in`  in  1  command is last beat of burst
- `set_cmd`  in  1  capture command at this posedge
- `ready`  out  1  queue can accept a command
- `gap`  in  4  idle cycles inserted after each accepted beat
- `wid`, `wdata`, `wstrb`, `wlast`  out  as inputs  AXI W payload
- `wvalid`  out  1  AXI W valid
- `wready`  in  1  AXI W ready
- `level`  out  `$clog2(DEPTH)+1`  commands held (pipe + FIFO)
- `bursts`  out  16  count of `wlast` handshakes, wraps at 2^16
- `overflow`  out  1  sticky: `set_cmd` while `!ready`

## Operation
- Capture: `set_cmd && ready` at a posedge pushes `{wid_in, wdata_in, wstrb_in, wlast_in}` into the delay pipe.
- The pipe has `LATENCY` registers; a valid flag travels with each stage. For `LATENCY`=0 the command enters the FIFO directly.
- `set_cmd && !ready` drops the command and sets `overflow`. Only reset clears `overflow`.
- `ready` = `level < DEPTH`, combinational from registered counts.
- Output states:
  - IDLE: `wvalid`=0.
  - VALID: `wvalid`=1; payload is the FIFO head.
  - GAP: `wvalid`=0; gap counter is running.
- IDLE to VALID when the FIFO is non-empty.
- VALID on `wvalid && wready`:
  - pop the FIFO;
  - if `wlast`, increment `bursts`;
  - load the gap counter with `gap`, sampled at that edge;
  - if `gap`=0, go to VALID when the FIFO still holds an entry after the pop, otherwise IDLE;
  - if `gap`≠0, go to GAP.
- GAP decrements the counter each cycle. At 0 it goes to VALID if the FIFO is non-empty, otherwise IDLE.
- Payload and `wvalid` are held stable while `wvalid && !wready`.
- Simultaneous push and pop: `level` stays unchanged.
- Push into an empty FIFO while `LATENCY`=0: `wvalid` rises at the following posedge, never in the same cycle.

## Timing
- Reset (asynchronous assert, synchronous-safe release) forces:
  - `wvalid`=0, `wid`/`wdata`/`wstrb`/`wlast`=0;
  - `level`=0, `bursts`=0, `overflow`=0, `ready`=1;
  - pipe and FIFO emptied, state IDLE.
- Reset mid-burst discards all queued commands; no partial beat is completed.
- Capture at posedge T gives the earliest `wvalid`=1 after posedge T+1+`LATENCY`.
- With `wready` tied high and `gap`=0, throughput is 1 beat/cycle.
- With `gap`=N, beats are N+1 cycles apart.
- `level` counts pipe and FIFO entries together and updates on the same edge as the push or pop.
- `bursts` wraps from 0xFFFF to 0.

## Configuration
- `SIMUL_AXI_WDATA_CHECK_EN` defined enables a burst-ID check at the output:
  - the `wid` of the first beat after a `wlast` (or after reset) is latched;
  - any later beat of the same burst with a different `wid` `$display`s an error and sets the sticky output `id_err` (1 bit, reset 0).
- Without the macro, `id_err` is still present and tied to 0; no check logic and no messages.

## Structure
- The shared simulation package holds:
  - the payload struct width helper (`ID_WIDTH+DATA_WIDTH+WSTB_WIDTH+1`);
  - the state encoding constants IDLE/VALID/GAP.
- One sub-module: `simul_fifo_sync`, a synchronous FIFO of parametric width and depth with a count output. It holds `DEPTH` entries and shares `level` accounting with the pipe.
- The delay pipe is inline, as a generate loop.

## Test plan
- Single beat, `LATENCY`=0, `gap`=0, `wready`=1: capture at T gives `wvalid` for one cycle after T+1, `bursts`=1, `level` back to 0.
- `LATENCY`=3, 4-beat burst with IDs 0x005: `wvalid` first rises after T+4, 4 consecutive beats, `wlast` on the 4th, `bursts`=1.
- `gap`=2, 3 queued beats, `wready`=1: beats at cycles k, k+3, k+6, `wvalid` low in between.
- `wready` low for 5 cycles on beat `wdata`=0xDEADBEEF: payload held constant and `wvalid` stays 1; pop occurs on the first `wready`=1.
- `DEPTH`=8, 9 consecutive `set_cmd` with `wready`=0: `ready` drops after the 8th, 9th dropped, `overflow`=1, `level`=8.
- `SIMUL_AXI_WDATA_CHECK_EN` defined, burst beats with `wid` 0x001 then 0x002: `id_err`=1 after the second beat. Repeat with `reset_n` pulsed mid-burst: all outputs return to reset values.
